// File: rtl/psum_wb_sched.sv
// PSUM writeback scheduler: tracks MAC contributions per bank, locks complete
// banks, and drains them round-robin as fixed-length bursts to the output buffer.
module psum_wb_sched #(
    parameter int PSUM_NUM     = 9,
    parameter int MAC_PER_PSUM = 9,
    parameter int CNT_WIDTH    = 4,
    parameter int LEN_WB       = 16,
    parameter int BEAT_WIDTH   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                PEBSCH_Sta,
    input  logic                PEBSCH_BlkEnd,
    input  logic [PSUM_NUM-1:0] MACSCH_Done,
    input  logic [PSUM_NUM-1:0] PSUMSCH_Idle,
    input  logic                BUFSCH_Rdy,
    output logic                SCHBUF_Val,
    output logic [3:0]          SCHBUF_ID,
    output logic                SCHBUF_Last,
    output logic [PSUM_NUM-1:0] SCHPSUM_Rd,
    output logic [PSUM_NUM-1:0] SCHARB_Busy,
    output logic                SCHPEB_Fnh,
    output logic                SCHPEB_Err
);

    localparam logic [CNT_WIDTH-1:0]  CNT_FULL  = CNT_WIDTH'(MAC_PER_PSUM);
    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(LEN_WB - 1);
    localparam logic [3:0]            LAST_BANK = 4'(PSUM_NUM - 1);

    typedef enum logic [0:0] {IDLE, XFER} state_t;

    state_t                state, state_nxt;
    logic [CNT_WIDTH-1:0]  cnt [PSUM_NUM];
    logic [CNT_WIDTH-1:0]  cnt_nxt [PSUM_NUM];
    logic [PSUM_NUM-1:0]   busy, busy_nxt;
    logic [PSUM_NUM-1:0]   elig;
    logic [3:0]            ptr, ptr_nxt, grant, grant_nxt, pick;
    logic [4:0]            idx;
    logic [BEAT_WIDTH-1:0] beat, beat_nxt;
    logic                  err, err_nxt, eob, eob_nxt, fnh, fnh_nxt;
    logic                  found, all_zero;

    assign elig = busy & PSUMSCH_Idle;

    // First eligible bank at or after the round-robin pointer, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = '0;
        for (int i = 0; i < PSUM_NUM; i++) begin
            idx = {1'b0, ptr} + 5'(i);
            if (idx >= 5'(PSUM_NUM)) idx = idx - 5'(PSUM_NUM);
            if (!found && elig[idx[3:0]]) begin
                found = 1'b1;
                pick  = idx[3:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        beat_nxt  = beat;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        busy_nxt  = busy;
        err_nxt   = err;
        eob_nxt   = eob;
        fnh_nxt   = fnh;
        all_zero  = 1'b1;

        for (int b = 0; b < PSUM_NUM; b++) begin
            if (MACSCH_Done[b]) begin
                if (busy[b]) begin
                    err_nxt = 1'b1;
                end else if (cnt[b] != CNT_FULL) begin
                    cnt_nxt[b] = cnt[b] + 1'b1;
                    if (cnt_nxt[b] == CNT_FULL) busy_nxt[b] = 1'b1;
                end
            end
        end

        // Block end locks partially filled banks so they flush too.
        if (PEBSCH_BlkEnd) begin
            eob_nxt = 1'b1;
            for (int b = 0; b < PSUM_NUM; b++) begin
                if (cnt_nxt[b] != '0 && cnt_nxt[b] < CNT_FULL) busy_nxt[b] = 1'b1;
            end
        end

        // Handshake: a beat transfers on a cycle where Val and Rdy are both
        // high; Val, ID and Last hold steady while Rdy is low.
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = pick;
                    beat_nxt  = '0;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (BUFSCH_Rdy) begin
                    beat_nxt = beat + 1'b1;
                    if (beat == LAST_BEAT) begin
                        cnt_nxt[grant]  = '0;
                        busy_nxt[grant] = 1'b0;
                        ptr_nxt         = (grant == LAST_BANK) ? 4'd0 : grant + 4'd1;
                        state_nxt       = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (PEBSCH_Sta) begin
            for (int b = 0; b < PSUM_NUM; b++) cnt_nxt[b] = '0;
            busy_nxt  = '0;
            err_nxt   = 1'b0;
            eob_nxt   = 1'b0;
            ptr_nxt   = ptr;
            state_nxt = IDLE;
        end

        for (int b = 0; b < PSUM_NUM; b++) begin
            if (cnt_nxt[b] != '0) all_zero = 1'b0;
        end

        // Finish holds its post-reset value until a block starts.
        if (PEBSCH_Sta)   fnh_nxt = 1'b0;
        else if (eob_nxt) fnh_nxt = all_zero && (state_nxt == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            beat  <= '0;
            ptr   <= '0;
            busy  <= '0;
            err   <= 1'b0;
            eob   <= 1'b0;
            fnh   <= 1'b1;
            for (int b = 0; b < PSUM_NUM; b++) cnt[b] <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            beat  <= beat_nxt;
            ptr   <= ptr_nxt;
            busy  <= busy_nxt;
            err   <= err_nxt;
            eob   <= eob_nxt;
            fnh   <= fnh_nxt;
            for (int b = 0; b < PSUM_NUM; b++) cnt[b] <= cnt_nxt[b];
        end
    end

    assign SCHBUF_Val  = (state == XFER);
    assign SCHBUF_ID   = grant;
    assign SCHBUF_Last = SCHBUF_Val && (beat == LAST_BEAT);
    assign SCHPSUM_Rd  = (SCHBUF_Val && BUFSCH_Rdy) ? ({{(PSUM_NUM-1){1'b0}}, 1'b1} << grant) : '0;
    assign SCHARB_Busy = busy;
    assign SCHPEB_Fnh  = fnh;
    assign SCHPEB_Err  = err;

endmodule

// File: tb/tb_psum_wb_sched.sv
// Bench for psum_wb_sched: directed scenarios plus randomized blocks checked
// against a bank-level reference model and a burst monitor.
module tb_psum_wb_sched;

    localparam int N = 9;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sta, blkend, rdy;
    logic [N-1:0] done, idle;
    logic         val, last, fnh, err;
    logic [3:0]   id;
    logic [N-1:0] rd, busy;

    psum_wb_sched dut (
        .clk(clk), .rst_n(rst_n), .PEBSCH_Sta(sta), .PEBSCH_BlkEnd(blkend),
        .MACSCH_Done(done), .PSUMSCH_Idle(idle), .BUFSCH_Rdy(rdy),
        .SCHBUF_Val(val), .SCHBUF_ID(id), .SCHBUF_Last(last), .SCHPSUM_Rd(rd),
        .SCHARB_Busy(busy), .SCHPEB_Fnh(fnh), .SCHPEB_Err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;
    bit order_on = 0;

    // Reference model at bank level
    int           m_cnt [N];
    logic [N-1:0] m_busy = '0;
    logic         m_err = 1'b0, m_eob = 1'b0, m_fnh = 1'b1;
    int           m_ptr = 0;
    logic [3:0]   exp_q [$];
    logic [3:0]   got_q [$];

    // Burst monitor state
    bit         in_burst = 0, prev_hold = 0, prev_last_hs = 0;
    logic [3:0] cur_id = '0;
    int         mon_beats = 0, rd_pulses = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic [N-1:0] exp_rd;
        if (prev_last_hs) chk("idle_gap", 32'(val), 32'(0));
        if (prev_hold) begin
            chk("val_hold", 32'(val), 32'(1));
            chk("id_hold", 32'(id), 32'(cur_id));
        end
        if (val) begin
            if (!in_burst) begin
                in_burst  = 1;
                cur_id    = id;
                mon_beats = 0;
                chk("id_range", 32'(id < 4'd9), 32'(1));
            end
            chk("id_stable", 32'(id), 32'(cur_id));
            exp_rd = rdy ? (N'(1) << cur_id) : '0;
            chk("rd", 32'(rd), 32'(exp_rd));
            chk("last", 32'(last), 32'(mon_beats == 15));
        end else begin
            in_burst = 0;
            chk("rd_idle", 32'(rd), 32'(0));
            chk("last_idle", 32'(last), 32'(0));
        end
        if (rd != '0) rd_pulses++;
        prev_hold    = val && !rdy && !sta;
        prev_last_hs = 0;
        if (val && rdy) begin
            mon_beats++;
            if (mon_beats == 16) begin
                got_q.push_back(cur_id);
                in_burst     = 0;
                prev_last_hs = !sta;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = ~rdy;
            default: rdy = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic m_upd_fnh();
        bit z = 1;
        foreach (m_cnt[b]) if (m_cnt[b] != 0) z = 0;
        if (m_eob && z) m_fnh = 1'b1;
    endtask

    task automatic m_sta();
        foreach (m_cnt[b]) m_cnt[b] = 0;
        m_busy = '0; m_err = 1'b0; m_eob = 1'b0; m_fnh = 1'b0;
    endtask

    task automatic m_done(input logic [N-1:0] dm);
        for (int b = 0; b < N; b++) begin
            if (dm[b]) begin
                if (m_busy[b]) m_err = 1'b1;
                else if (m_cnt[b] < 9) begin
                    m_cnt[b]++;
                    if (m_cnt[b] == 9) m_busy[b] = 1'b1;
                end
            end
        end
    endtask

    task automatic m_blkend();
        m_eob = 1'b1;
        for (int b = 0; b < N; b++) if (m_cnt[b] > 0 && m_cnt[b] < 9) m_busy[b] = 1'b1;
        m_upd_fnh();
    endtask

    task automatic consume();
        logic [3:0] g, e;
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            chk("burst_locked", 32'(m_busy[g]), 32'(1));
            if (order_on) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hF;
                chk("burst_order", 32'(g), 32'(e));
            end
            m_cnt[g]  = 0;
            m_busy[g] = 1'b0;
            m_ptr     = (int'(g) + 1) % N;
            m_upd_fnh();
        end
    endtask

    task automatic post_checks();
        chk("busy", 32'(busy), 32'(m_busy));
        chk("err", 32'(err), 32'(m_err));
        chk("fnh", 32'(fnh), 32'(m_fnh));
    endtask

    task automatic step(input logic [N-1:0] dm, input logic be, input logic st);
        done = dm; blkend = be; sta = st;
        cyc();
        done = '0; blkend = 1'b0; sta = 1'b0;
        if (st) m_sta();
        else begin
            m_done(dm);
            if (be) m_blkend();
        end
        consume();
        post_checks();
    endtask

    task automatic drain(input bit ordered, input int mode);
        int p, n;
        logic [N-1:0] pend;
        bit hit;
        idle = '1;
        rdy_mode = mode;
        order_on = ordered;
        exp_q.delete();
        if (ordered) begin
            p = m_ptr;
            pend = m_busy;
            while (pend != '0) begin
                hit = 0;
                for (int i = 0; i < N; i++) begin
                    if (!hit && pend[(p + i) % N]) begin
                        hit = 1;
                        exp_q.push_back(4'((p + i) % N));
                        pend[(p + i) % N] = 1'b0;
                        p = ((p + i) % N + 1) % N;
                    end
                end
            end
        end
        n = 0;
        while (m_busy != '0 && n < 3000) begin
            cyc();
            consume();
            post_checks();
            n++;
        end
        chk("drain_in_time", 32'(n < 3000), 32'(1));
        if (ordered) chk("order_left", 32'(exp_q.size()), 32'(0));
        order_on = 0;
        rdy_mode = 0;
    endtask

    initial begin
        int n, rd0;
        logic [N-1:0] dm;
        rst_n = 1'b0; sta = 1'b0; blkend = 1'b0; done = '0; idle = '1; rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_val", 32'(val), 32'(0));
        chk("rst_id", 32'(id), 32'(0));
        chk("rst_last", 32'(last), 32'(0));
        chk("rst_rd", 32'(rd), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_fnh", 32'(fnh), 32'(1));
        chk("rst_err", 32'(err), 32'(0));
        rst_n = 1'b1;
        repeat (3) begin cyc(); post_checks(); end

        // Block start, then bank 3 completes: grant latency and one burst
        step('0, 0, 1);
        for (int k = 0; k < 8; k++) step(N'(1) << 3, 0, 0);
        rd0 = rd_pulses;
        step(N'(1) << 3, 0, 0);
        chk("lat_val0", 32'(val), 32'(0));
        cyc();
        chk("lat_val1", 32'(val), 32'(1));
        chk("lat_id", 32'(id), 32'(3));
        drain(1, 0);
        chk("b3_rd_pulses", 32'(rd_pulses - rd0), 32'(16));

        // Bank 4 moves the pointer to 5; then 0, 4, 8 lock together
        for (int k = 0; k < 9; k++) step(N'(1) << 4, 0, 0);
        drain(1, 0);
        idle = '0;
        for (int k = 0; k < 9; k++) step(9'b1_0001_0001, 0, 0);
        drain(1, 0);

        // Backpressure: banks 3 and 7 drained with Rdy toggling
        idle = '0;
        for (int k = 0; k < 9; k++) step(9'b0_1000_1000, 0, 0);
        rd0 = rd_pulses;
        drain(1, 1);
        chk("bp_rd_pulses", 32'(rd_pulses - rd0), 32'(32));

        // Partial flush: only bank 2 holds contributions
        step('0, 0, 1);
        for (int k = 0; k < 5; k++) step(N'(1) << 2, 0, 0);
        step('0, 1, 0);
        chk("flush_busy", 32'(busy), 32'(9'h004));
        drain(1, 0);
        chk("flush_fnh", 32'(fnh), 32'(1));

        // Contribution into a locked bank raises a sticky error
        step('0, 0, 1);
        idle = ~(N'(1) << 1);
        for (int k = 0; k < 9; k++) step(N'(1) << 1, 0, 0);
        step(N'(1) << 1, 0, 0);
        chk("err_set", 32'(err), 32'(1));
        repeat (3) step('0, 0, 0);
        drain(1, 0);
        chk("err_sticky", 32'(err), 32'(1));
        step('0, 0, 1);
        chk("err_clear", 32'(err), 32'(0));

        // Abort a burst in flight at beat 7
        for (int k = 0; k < 9; k++) step(N'(1) << 5, 0, 0);
        n = 0;
        while (!(in_burst && mon_beats == 7) && n < 100) begin cyc(); consume(); n++; end
        chk("abort_reached", 32'(n < 100), 32'(1));
        step('0, 0, 1);
        chk("abort_val", 32'(val), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_fnh", 32'(fnh), 32'(0));
        repeat (3) step('0, 0, 0);

        // Randomized blocks: contributions, idle gating and backpressure
        for (int r = 0; r < 4; r++) begin
            step('0, 0, 1);
            rdy_mode = 2;
            for (int c = 0; c < 120; c++) begin
                idle = N'($urandom) | N'($urandom);
                dm   = N'($urandom) & N'($urandom) & N'($urandom) & ~m_busy;
                step(dm, c == 119, 0);
            end
            drain(0, 2);
            chk("rand_fnh", 32'(fnh), 32'(1));
            chk("rand_err", 32'(err), 32'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
